// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit: funct3 codes, FSM state
// encoding and lane count.
package lsu_pkg;

    localparam int BYTES = 4;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } load_f3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0,
        F3_SH = 3'd1,
        F3_SW = 3'd2
    } store_f3_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;
    localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/dmem_align.sv
// Combinational RISC-V lane logic: store byte enables and lane steering, load
// byte/halfword extraction with extension, and misalignment/illegal-funct3 flags.
module dmem_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rword[7:0];
        case (addr_lo)
            2'd0: rbyte = rword[7:0];
            2'd1: rbyte = rword[15:8];
            2'd2: rbyte = rword[23:16];
            2'd3: rbyte = rword[31:24];
            default: rbyte = rword[7:0];
        endcase
        rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        be         = 4'b0000;
        wlanes     = '0;
        rdata      = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        if (we) begin
            // Narrow stores replicate their data so the enabled lanes always see it.
            case (funct3)
                F3_SB: begin
                    be     = 4'b0001 << addr_lo;
                    wlanes = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wlanes     = {2{wdata[15:0]}};
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    be         = 4'b1111;
                    wlanes     = wdata;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:  rdata = {{24{rbyte[7]}}, rbyte};
                F3_LBU: rdata = {24'h0, rbyte};
                F3_LH: begin
                    rdata      = {{16{rhalf[15]}}, rhalf};
                    misaligned = addr_lo[0];
                end
                F3_LHU: begin
                    rdata      = {16'h0, rhalf};
                    misaligned = addr_lo[0];
                end
                F3_LW: begin
                    rdata      = rword;
                    misaligned = |addr_lo;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-port word array with a load/store front end: valid/ready request,
// optional wait states, and a one-cycle registered response pulse.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int    ADDRESS_WIDTH = 9,
    parameter int    XLEN          = 32,
    parameter int    WAIT_STATES   = 0,
    parameter string INIT_FILE     = "mem.txt"
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    if (XLEN != 32) begin : g_bad_xlen
        $error("dmem_lsu supports XLEN=32 only");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("dmem_lsu WAIT_STATES must be 0..15");
    end

    logic [XLEN-1:0] mem_q [DEPTH];

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [2:0]               f3_q, f3_d;
    logic [ADDRESS_WIDTH+1:0] addr_q, addr_d;
    logic [XLEN-1:0]          wdata_q, wdata_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]          rsp_rdata_q, rsp_rdata_d;
    logic                     rsp_err_q, rsp_err_d;

    logic                     in_idle;
    logic                     al_we;
    logic [2:0]               al_f3;
    logic [1:0]               al_lo;
    logic [XLEN-1:0]          al_wdata;
    logic [3:0]               al_be;
    logic [XLEN-1:0]          al_wlanes;
    logic [XLEN-1:0]          al_rdata;
    logic                     al_misaligned;
    logic                     al_illegal;
    logic                     out_of_range;
    logic                     req_err;
    logic [ADDRESS_WIDTH-1:0] word_idx;

    // In IDLE the aligner judges the live request; afterwards it works on the latched one.
    assign in_idle  = (state_q == ST_IDLE);
    assign al_we    = in_idle ? req_we           : we_q;
    assign al_f3    = in_idle ? req_funct3       : f3_q;
    assign al_lo    = in_idle ? req_addr[1:0]    : addr_q[1:0];
    assign al_wdata = in_idle ? req_wdata        : wdata_q;
    assign word_idx = addr_q[ADDRESS_WIDTH+1:2];

    dmem_align u_align (
        .we         (al_we),
        .funct3     (al_f3),
        .addr_lo    (al_lo),
        .wdata      (al_wdata),
        .rword      (mem_q[word_idx]),
        .be         (al_be),
        .wlanes     (al_wlanes),
        .rdata      (al_rdata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign out_of_range = |req_addr[XLEN-1:ADDRESS_WIDTH+2];
    assign req_err      = al_misaligned | al_illegal | out_of_range;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[ADDRESS_WIDTH+1:0];
                    wdata_d = req_wdata;
                    cnt_d   = 4'd0;
                    if (req_err) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES - 1)) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                if (!we_q) begin
                    rsp_rdata_d = al_rdata;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Reset forces state_q out of ACCESS asynchronously, so a store caught by reset never commits.
    always_ff @(posedge clk) begin
        if (state_q == ST_ACCESS && we_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (al_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= al_wlanes[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: one instance without wait states and one with three,
// driven by directed and random requests against a byte-level memory model.
module tb_dmem_lsu;

  localparam int AW    = 9;
  localparam int DEPTH = 2 ** AW;
  localparam int WIN   = 32;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_funct3[2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   [2];
  int rsp_seen [2];

  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  always #5 clk = ~clk;

  dmem_lsu #(.ADDRESS_WIDTH(AW), .XLEN(32), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_lsu #(.ADDRESS_WIDTH(AW), .XLEN(32), .WAIT_STATES(3), .INIT_FILE("")) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  always @(negedge clk) begin
    if (rsp_valid[0] === 1'b1) pulses[0]++;
    if (rsp_valid[1] === 1'b1) pulses[1]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: a byte-addressed memory plus the RISC-V size/sign/legality rules.
  task automatic model(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd);
    int  size;
    bit  sgn;
    bit  legal;
    int  a;
    rd    = '0;
    size  = 1;
    sgn   = 1'b0;
    legal = 1'b1;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err = !legal || (addr % size != 0) || (addr >= 4 * DEPTH);
    if (!err) begin
      for (int k = 0; k < size; k++) begin
        a = int'(addr) + k;
        if (we) ref_mem[d][a / 4][8 * (a % 4) +: 8] = wd[8 * k +: 8];
        else    rd[8 * k +: 8] = ref_mem[d][a / 4][8 * (a % 4) +: 8];
      end
      if (!we && sgn && rd[8 * size - 1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
    end
  endtask

  task automatic do_req(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] got_rd, output logic got_err);
    bit          e;
    logic [31:0] r;
    int          w;
    int          lat;
    bit          seen;
    logic [31:0] exp_rd;
    logic        exp_e;
    got_rd  = 'x;
    got_err = 1'bx;
    model(d, we, f3, addr, wd, e, r);
    exp_q.push_back(r);
    exp_err_q.push_back(e);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    w = 0;
    while (req_ready[d] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (req_ready[d] !== 1'b1) begin
      check("ready_timeout", {31'h0, req_ready[d]}, 32'h1);
      req_valid[d] = 1'b0;
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end else begin
      @(posedge clk);
      #1;
      // Keep valid up with a different in-range store: it must not be taken while busy.
      req_we[d]     = 1'b1;
      req_funct3[d] = 3'd2;
      req_addr[d]   = $urandom & 32'h0000_007C;
      req_wdata[d]  = $urandom;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 40) begin
        @(negedge clk);
        lat++;
        check("ready_busy", {31'h0, req_ready[d]}, 32'h0);
        if (rsp_valid[d] === 1'b1) seen = 1'b1;
      end
      req_valid[d] = 1'b0;
      exp_rd = exp_q.pop_front();
      exp_e  = exp_err_q.pop_front();
      if (!seen) begin
        check("rsp_timeout", 32'h0, 32'h1);
      end else begin
        rsp_seen[d]++;
        got_rd  = rsp_rdata[d];
        got_err = rsp_err[d];
        check("latency", lat, exp_e ? 1 : 2 + wait_of(d));
        check("rsp_err", {31'h0, rsp_err[d]}, {31'h0, exp_e});
        check("rsp_rdata", rsp_rdata[d], exp_rd);
        @(negedge clk);
        check("rsp_pulse_end", {31'h0, rsp_valid[d]}, 32'h0);
        check("rdata_cleared", rsp_rdata[d], 32'h0);
        check("err_cleared", {31'h0, rsp_err[d]}, 32'h0);
        check("ready_back", {31'h0, req_ready[d]}, 32'h1);
      end
    end
  endtask

  task automatic rand_req(input int d);
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rd;
    logic        er;
    we = 1'($urandom_range(0, 1));
    f3 = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 3) != 0) f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 4) == 0 && !we) f3 = 3'($urandom_range(4, 5));
    addr = $urandom_range(0, 4 * WIN - 1);
    if ($urandom_range(0, 2) != 0) addr = addr & ~32'h1;
    if ($urandom_range(0, 2) == 0) addr = addr & ~32'h3;
    if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(11, 31));
    do_req(d, we, f3, addr, $urandom, rd, er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w;
    bit          hit;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'd0;
      req_addr[d] = '0; req_wdata[d] = '0; pulses[d] = 0; rsp_seen[d] = 0;
      for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'h0, req_ready[d]}, 32'h0);
      check("reset_rsp_valid", {31'h0, rsp_valid[d]}, 32'h0);
      check("reset_rdata", rsp_rdata[d], 32'h0);
      check("reset_err", {31'h0, rsp_err[d]}, 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    check("ready_before_edge", {31'h0, req_ready[0]}, 32'h0);
    @(negedge clk);
    check("ready_after_edge0", {31'h0, req_ready[0]}, 32'h1);
    check("ready_after_edge1", {31'h0, req_ready[1]}, 32'h1);
    repeat (3) @(negedge clk);
    check("no_spurious_rsp", pulses[0] + pulses[1], 0);

    // Fill the working window of both arrays through the port.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < WIN; i++) do_req(d, 1'b1, 3'd2, 32'(4 * i), $urandom, rd, er);

    do_req(0, 1'b1, 3'd2, 32'h10, 32'h8081_7F02, rd, er);
    do_req(0, 1'b1, 3'd2, 32'h20, 32'h1122_3344, rd, er);
    do_req(0, 1'b0, 3'd0, 32'h11, 32'h0, rd, er); check("lb_0x11", rd, 32'h0000_007F);
    do_req(0, 1'b0, 3'd0, 32'h13, 32'h0, rd, er); check("lb_0x13", rd, 32'hFFFF_FF80);
    do_req(0, 1'b0, 3'd5, 32'h12, 32'h0, rd, er); check("lhu_0x12", rd, 32'h0000_8081);
    do_req(0, 1'b0, 3'd1, 32'h12, 32'h0, rd, er); check("lh_0x12", rd, 32'hFFFF_8081);
    do_req(0, 1'b1, 3'd0, 32'h21, 32'h0000_00AA, rd, er); check("sb_err", {31'h0, er}, 32'h0);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er); check("lw_after_sb", rd, 32'h1122_AA44);
    do_req(0, 1'b1, 3'd1, 32'h22, 32'h0000_BEEF, rd, er);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er); check("lw_after_sh", rd, 32'hBEEF_AA44);

    do_req(0, 1'b0, 3'd2, 32'h21, 32'h0, rd, er); check("lw_mis_err", {31'h0, er}, 32'h1);
    check("lw_mis_rdata", rd, 32'h0);
    do_req(0, 1'b1, 3'd1, 32'h23, 32'h0000_1234, rd, er); check("sh_mis_err", {31'h0, er}, 32'h1);
    do_req(0, 1'b0, 3'd3, 32'h20, 32'h0, rd, er); check("f3_3_err", {31'h0, er}, 32'h1);
    do_req(0, 1'b1, 3'd0, 32'h20, 32'h0000_0055, rd, er); check("sb_legal", {31'h0, er}, 32'h0);
    do_req(0, 1'b1, 3'd4, 32'h20, 32'h0000_0066, rd, er); check("store_f3_4_err", {31'h0, er}, 32'h1);
    do_req(0, 1'b1, 3'd2, 32'h800, 32'hDEAD_BEEF, rd, er); check("sw_oor_err", {31'h0, er}, 32'h1);
    do_req(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er); check("lw_unchanged", rd, 32'hBEEF_AA55);
    do_req(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, er);

    // Wait-state instance: long latency and a reset during WAIT dropping a store.
    do_req(1, 1'b1, 3'd2, 32'h40, 32'hCAFE_F00D, rd, er);
    do_req(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, er); check("ws_lw", rd, 32'hCAFE_F00D);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h40; req_wdata[1] = 32'hDEAD_BEEF;
    w = 0;
    while (req_ready[1] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ws_reset_accept", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("ws_reset_ready", {31'h0, req_ready[1]}, 32'h0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    hit = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) hit = 1'b1;
    end
    check("ws_reset_no_rsp", {31'h0, hit}, 32'h0);
    do_req(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, er); check("ws_reset_no_write", rd, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) rand_req(0);
    for (int i = 0; i < 40; i++) rand_req(1);

    repeat (4) @(negedge clk);
    check("pulse_count0", pulses[0], rsp_seen[0]);
    check("pulse_count1", pulses[1], rsp_seen[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
